cl_frame_rx: RTL and testbench

CL_FRAME_RX -- requirements
Module: cl_frame_rx

---
 rtl/cl_frame_rx.sv | 188 ++++++++++++++++++
 tb/tb_cl_frame_rx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cl_frame_rx.sv
// Camera Link 10-tap frame receiver: captures taps and framing strobes, tracks line/frame
// geometry and emits pixel words with SOF/EOL/EOF markers. Define CL_RX_TOGGLE_CHECK_EN for the bit-4 toggle check.
module cl_frame_rx #(
  parameter int N_COL = 6,
  parameter int N_ROW = 4
) (
  input  logic        cl_z_pclk,
  input  logic        reset,
  input  logic        cl_fval,
  input  logic        cl_z_lval,
  input  logic [7:0]  cl_port_a,
  input  logic [7:0]  cl_port_b,
  input  logic [7:0]  cl_port_c,
  input  logic [7:0]  cl_port_d,
  input  logic [7:0]  cl_port_e,
  input  logic [7:0]  cl_port_f,
  input  logic [7:0]  cl_port_g,
  input  logic [7:0]  cl_port_h,
  input  logic [7:0]  cl_port_i,
  input  logic [7:0]  cl_port_j,
  output logic [79:0] pix_data,
  output logic        pix_valid,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_eof,
  output logic [19:0] frame_cnt,
  output logic        line_err,
  output logic        row_err,
  output logic        toggle_err
);

  typedef enum logic [1:0] {SYNC, IDLE, LINE, GAP} state_t;

  localparam logic [10:0] COL_NUM = 11'(N_COL);
  localparam logic [10:0] ROW_NUM = 11'(N_ROW);

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  // Capture stage; c_vld marks that at least one real sample has been taken since reset.
  logic        c_fval, c_lval, c_vld;
  logic [79:0] c_data;

  // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge cl_z_pclk or posedge reset) begin
    if (reset) begin
      c_fval <= 1'b0;
      c_lval <= 1'b0;
      c_vld  <= 1'b0;
      c_data <= '0;
    end else begin
      c_fval <= cl_fval;
      c_lval <= cl_z_lval;
      c_vld  <= 1'b1;
      c_data <= {cl_port_a, cl_port_b, cl_port_c, cl_port_d, cl_port_e,
                 cl_port_f, cl_port_g, cl_port_h, cl_port_i, cl_port_j};
    end
  end

  state_t      state, state_nxt;
  logic [10:0] col_cnt, col_nxt, row_cnt, row_nxt;
  logic [10:0] pcol, prow;
  logic        pix, frame_inc, line_end, frame_end;
  logic        line_err_set, row_err_set, pix_ok;

  always_ff @(posedge cl_z_pclk or posedge reset) begin
    if (reset) begin
      state   <= SYNC;
      col_cnt <= '0;
      row_cnt <= '0;
    end else begin
      state   <= state_nxt;
      col_cnt <= col_nxt;
      row_cnt <= row_nxt;
    end
  end

  // NOTE: every signal gets a default before the case so no latch can be inferred.
  always_comb begin
    state_nxt = state;
    col_nxt   = col_cnt;
    row_nxt   = row_cnt;
    pix       = 1'b0;
    pcol      = col_cnt;
    prow      = row_cnt;
    frame_inc = 1'b0;
    line_end  = 1'b0;
    frame_end = 1'b0;
    unique case (state)
      SYNC: if (c_vld && !c_fval) state_nxt = IDLE;
      IDLE: begin
        if (c_fval) begin
          frame_inc = 1'b1;
          row_nxt   = '0;
          if (c_lval) begin
            state_nxt = LINE;
            pix       = 1'b1;
            pcol      = '0;
            prow      = '0;
            col_nxt   = 11'd1;
          end else begin
            state_nxt = GAP;
          end
        end
      end
      LINE: begin
        if (!c_fval) begin
          state_nxt = IDLE;
          line_end  = 1'b1;
          frame_end = 1'b1;
        end else if (!c_lval) begin
          state_nxt = GAP;
          line_end  = 1'b1;
        end else begin
          pix     = 1'b1;
          col_nxt = sat_inc(col_cnt);
        end
      end
      GAP: begin
        if (!c_fval) begin
          state_nxt = IDLE;
          frame_end = 1'b1;
        end else if (c_lval) begin
          state_nxt = LINE;
          pix       = 1'b1;
          pcol      = '0;
          col_nxt   = 11'd1;
        end
      end
      default: state_nxt = SYNC;
    endcase
    if (line_end) row_nxt = sat_inc(row_cnt);
  end

  // Row check sees the row count after any line closed by the same fval fall.
  assign line_err_set = line_end && (col_cnt != COL_NUM);
  assign row_err_set  = frame_end && (row_nxt != ROW_NUM);
  assign pix_ok       = pix && (pcol < COL_NUM) && (prow < ROW_NUM);

  always_ff @(posedge cl_z_pclk or posedge reset) begin
    if (reset) begin
      pix_data  <= '0;
      pix_valid <= 1'b0;
      pix_sof   <= 1'b0;
      pix_eol   <= 1'b0;
      pix_eof   <= 1'b0;
      frame_cnt <= '0;
      line_err  <= 1'b0;
      row_err   <= 1'b0;
    end else begin
      pix_valid <= pix_ok;
      pix_sof   <= pix_ok && (pcol == '0) && (prow == '0);
      pix_eol   <= pix_ok && (pcol == COL_NUM - 11'd1);
      pix_eof   <= pix_ok && (pcol == COL_NUM - 11'd1) && (prow == ROW_NUM - 11'd1);
      if (pix_ok) pix_data <= c_data;
      if (frame_inc) frame_cnt <= frame_cnt + 20'd1;
      line_err  <= line_err | line_err_set;
      row_err   <= row_err | row_err_set;
    end
  end

`ifdef CL_RX_TOGGLE_CHECK_EN
  // Each tap's bit 4 must differ from its previous captured value on every cycle.
  logic [9:0] cur_b4, prev_b4;
  logic       prev_vld;

  always_comb begin
    cur_b4 = '0;
    for (int i = 0; i < 10; i++) cur_b4[9-i] = c_data[76-8*i];
  end

  always_ff @(posedge cl_z_pclk or posedge reset) begin
    if (reset) begin
      prev_b4    <= '0;
      prev_vld   <= 1'b0;
      toggle_err <= 1'b0;
    end else begin
      prev_b4    <= cur_b4;
      prev_vld   <= c_vld;
      toggle_err <= toggle_err | (prev_vld && |(~(cur_b4 ^ prev_b4)));
    end
  end
`else
  assign toggle_err = 1'b0;
`endif

endmodule

// File: tb/tb_cl_frame_rx.sv
// Directed bench for cl_frame_rx: nominal frame, short/long lines, short frame, mid-frame reset
// and (with CL_RX_TOGGLE_CHECK_EN) the bit-4 toggle check.
module tb_cl_frame_rx;

  logic        cl_z_pclk = 1'b0;
  logic        reset = 1'b1;
  logic        cl_fval = 1'b0;
  logic        cl_z_lval = 1'b0;
  logic [7:0]  cl_port_a = '0, cl_port_b = '0, cl_port_c = '0, cl_port_d = '0, cl_port_e = '0;
  logic [7:0]  cl_port_f = '0, cl_port_g = '0, cl_port_h = '0, cl_port_i = '0, cl_port_j = '0;
  logic [79:0] pix_data;
  logic        pix_valid, pix_sof, pix_eol, pix_eof;
  logic [19:0] frame_cnt;
  logic        line_err, row_err, toggle_err;

  cl_frame_rx #(.N_COL(6), .N_ROW(4)) dut (
    .cl_z_pclk(cl_z_pclk), .reset(reset), .cl_fval(cl_fval), .cl_z_lval(cl_z_lval),
    .cl_port_a(cl_port_a), .cl_port_b(cl_port_b), .cl_port_c(cl_port_c), .cl_port_d(cl_port_d),
    .cl_port_e(cl_port_e), .cl_port_f(cl_port_f), .cl_port_g(cl_port_g), .cl_port_h(cl_port_h),
    .cl_port_i(cl_port_i), .cl_port_j(cl_port_j),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_eol(pix_eol),
    .pix_eof(pix_eof), .frame_cnt(frame_cnt), .line_err(line_err), .row_err(row_err),
    .toggle_err(toggle_err)
  );

  always #5 cl_z_pclk = ~cl_z_pclk;

  int   n_assert = 0, n_fail = 0;
  int   dcnt = 0, last_t = 0, last_e = 0;
  logic hold_en = 1'b0, hold_val = 1'b0, hold_skip = 1'b0;

  // Tap byte for drive count t and port p; bit 4 toggles every clock unless port e is held.
  function automatic logic [7:0] pat(input int t, input int p);
    logic [7:0]  b;
    logic [31:0] tt;
    tt = t;
    b = 8'(t * 37 + p * 11 + 5);
    b[4] = tt[0];
    if (p == 4 && hold_en) b[4] = hold_val;
    return b;
  endfunction

  function automatic logic [79:0] exp_word(input int t);
    logic [79:0] w;
    w = '0;
    for (int p = 0; p < 10; p++) w[79-8*p -: 8] = pat(t, p);
    return w;
  endfunction

  // Output monitor, sampled 1 ns after each rising edge.
  int          ecnt = 0, n_valid = 0, n_sof = 0, n_eol = 0, n_eof = 0, n_hold = 0, n_stray = 0;
  int          sof_edge = -1, eof_at = -1;
  logic [79:0] sof_data = '0, eof_data = '0, prev_data = '0;
  int          eol_q[$];

  always @(posedge cl_z_pclk) begin
    #1;
    ecnt++;
    if (pix_valid) begin
      n_valid++;
      if (pix_sof) begin n_sof++; sof_edge = ecnt; sof_data = pix_data; end
      if (pix_eol) begin n_eol++; eol_q.push_back(n_valid); end
      if (pix_eof) begin n_eof++; eof_at = n_valid; eof_data = pix_data; end
    end else begin
      if (pix_sof || pix_eol || pix_eof) n_stray++;
      if (!hold_skip && pix_data !== prev_data) n_hold++;
    end
    prev_data = pix_data;
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic f, input logic l);
    @(negedge cl_z_pclk);
    cl_fval   = f;
    cl_z_lval = l;
    {cl_port_a, cl_port_b, cl_port_c, cl_port_d, cl_port_e,
     cl_port_f, cl_port_g, cl_port_h, cl_port_i, cl_port_j} = exp_word(dcnt);
    last_t = dcnt;
    last_e = ecnt;
    dcnt++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0);
  endtask

  int vbase, sbase, ebase, fbase, f_t0, f_e0, f_tl;

  task automatic snap();
    vbase = n_valid; sbase = n_sof; ebase = n_eol; fbase = n_eof;
    eol_q.delete();
  endtask

  function automatic int eol_rel(input int k);
    if (k < eol_q.size()) return eol_q[k] - vbase;
    return -1;
  endfunction

  // fval rises with the first lval; 7-clock lval gaps; optional tail gap before fval falls.
  task automatic run_frame(input int l0, l1, l2, l3, input int nlines,
                           input bit tail_gap, input bit end_frame);
    int lens[4];
    lens = '{l0, l1, l2, l3};
    for (int i = 0; i < nlines; i++) begin
      for (int c = 0; c < lens[i]; c++) begin
        tick(1'b1, 1'b1);
        if (i == 0 && c == 0) begin f_t0 = last_t; f_e0 = last_e; end
        f_tl = last_t;
      end
      if (i < nlines - 1 || tail_gap) repeat (7) tick(1'b1, 1'b0);
    end
    if (end_frame) tick(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    hold_skip = 1'b1;
    tick(1'b0, 1'b0);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(3);
    hold_skip = 1'b0;
  endtask

  initial begin
    // Reset state
    hold_skip = 1'b1;
    idle(3);
    check("rst_valid", 80'(pix_valid), 80'd0);
    check("rst_marks", 80'({pix_sof, pix_eol, pix_eof}), 80'd0);
    check("rst_data", pix_data, 80'd0);
    check("rst_frame_cnt", 80'(frame_cnt), 80'd0);
    check("rst_errs", 80'({line_err, row_err, toggle_err}), 80'd0);
    reset = 1'b0;
    idle(2);
    hold_skip = 1'b0;

    // Nominal 4x6 frame
    idle(40);
    snap();
    run_frame(6, 6, 6, 6, 4, 1'b1, 1'b1);
    idle(5);
    check("nom_valid", 80'(n_valid - vbase), 80'd24);
    check("nom_sof", 80'(n_sof - sbase), 80'd1);
    check("nom_eol", 80'(n_eol - ebase), 80'd4);
    check("nom_eof", 80'(n_eof - fbase), 80'd1);
    check("nom_eof_idx", 80'(eof_at - vbase), 80'd24);
    check("nom_eol0_idx", 80'(eol_rel(0)), 80'd6);
    check("nom_eol3_idx", 80'(eol_rel(3)), 80'd24);
    check("nom_sof_latency", 80'(sof_edge), 80'(f_e0 + 2));
    check("nom_sof_data", sof_data, exp_word(f_t0));
    check("nom_eof_data", eof_data, exp_word(f_tl));
    check("nom_frame_cnt", 80'(frame_cnt), 80'd1);
    check("nom_errs", 80'({line_err, row_err}), 80'd0);

    // lval while fval is low is ignored
    snap();
    repeat (5) tick(1'b0, 1'b1);
    idle(5);
    check("lval_only_valid", 80'(n_valid - vbase), 80'd0);
    check("lval_only_frame_cnt", 80'(frame_cnt), 80'd1);
    check("lval_only_errs", 80'({line_err, row_err}), 80'd0);

    // Reset during line 1, rest of that frame discarded, then two full frames
    idle(10);
    repeat (6) tick(1'b1, 1'b1);
    repeat (7) tick(1'b1, 1'b0);
    repeat (2) tick(1'b1, 1'b1);
    hold_skip = 1'b1;
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    snap();
    repeat (4) tick(1'b1, 1'b1);
    hold_skip = 1'b0;
    check("midrst_frame_cnt", 80'(frame_cnt), 80'd0);
    repeat (7) tick(1'b1, 1'b0);
    repeat (2) begin
      repeat (6) tick(1'b1, 1'b1);
      repeat (7) tick(1'b1, 1'b0);
    end
    tick(1'b0, 1'b0);
    idle(5);
    check("midrst_discard_valid", 80'(n_valid - vbase), 80'd0);
    check("midrst_discard_marks", 80'(n_sof - sbase + n_eol - ebase + n_eof - fbase), 80'd0);
    snap();
    idle(40);
    run_frame(6, 6, 6, 6, 4, 1'b1, 1'b1);
    idle(40);
    run_frame(6, 6, 6, 6, 4, 1'b1, 1'b1);
    idle(5);
    check("midrst_valid", 80'(n_valid - vbase), 80'd48);
    check("midrst_sof", 80'(n_sof - sbase), 80'd2);
    check("midrst_eol", 80'(n_eol - ebase), 80'd8);
    check("midrst_eof", 80'(n_eof - fbase), 80'd2);
    check("midrst_frame_cnt2", 80'(frame_cnt), 80'd2);
    check("midrst_errs", 80'({line_err, row_err}), 80'd0);

    // Long line 0 (8 clocks): pixels 7-8 dropped
    do_reset();
    snap();
    run_frame(8, 6, 6, 6, 4, 1'b1, 1'b1);
    idle(5);
    check("long_valid", 80'(n_valid - vbase), 80'd24);
    check("long_eol0_idx", 80'(eol_rel(0)), 80'd6);
    check("long_eol1_idx", 80'(eol_rel(1)), 80'd12);
    check("long_eof", 80'(n_eof - fbase), 80'd1);
    check("long_line_err", 80'(line_err), 80'd1);
    check("long_row_err", 80'(row_err), 80'd0);

    // Short line 2 (5 clocks); last line closed by the fval fall itself
    do_reset();
    snap();
    run_frame(6, 6, 5, 6, 4, 1'b0, 1'b1);
    idle(5);
    check("short_valid", 80'(n_valid - vbase), 80'd23);
    check("short_eol", 80'(n_eol - ebase), 80'd3);
    check("short_eol1_idx", 80'(eol_rel(1)), 80'd12);
    check("short_eol2_idx", 80'(eol_rel(2)), 80'd23);
    check("short_line_err", 80'(line_err), 80'd1);
    check("short_row_err", 80'(row_err), 80'd0);
    check("short_frame_cnt", 80'(frame_cnt), 80'd1);

    // Three-line frame: row_err only once fval falls
    do_reset();
    snap();
    run_frame(6, 6, 6, 0, 3, 1'b1, 1'b0);
    check("rows3_pre_row_err", 80'(row_err), 80'd0);
    tick(1'b0, 1'b0);
    idle(5);
    check("rows3_row_err", 80'(row_err), 80'd1);
    check("rows3_valid", 80'(n_valid - vbase), 80'd18);
    check("rows3_eof", 80'(n_eof - fbase), 80'd0);
    check("rows3_frame_cnt", 80'(frame_cnt), 80'd1);
    check("rows3_line_err", 80'(line_err), 80'd0);

`ifdef CL_RX_TOGGLE_CHECK_EN
    check("toggle_clean", 80'(toggle_err), 80'd0);
    hold_val = pat(last_t, 4) >> 4;
    hold_en  = 1'b1;
    idle(2);
    hold_en  = 1'b0;
    idle(5);
    check("toggle_set", 80'(toggle_err), 80'd1);
    idle(10);
    check("toggle_sticky", 80'(toggle_err), 80'd1);
`else
    check("toggle_off", 80'(toggle_err), 80'd0);
`endif

    check("hold_when_invalid", 80'(n_hold), 80'd0);
    check("markers_unqualified", 80'(n_stray), 80'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
